// File: rtl/adsr_pkg.sv
// rtl/adsr_pkg.sv - state encoding, amplitude limit and register map for the ADSR envelope generator
package adsr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

   // Amplitude is Q2.30 internally; MAX corresponds to 1.0 (0x4000 on env_out)
   localparam logic [31:0] AMP_MAX     = 32'h4000_0000;
   localparam logic [15:0] SUSTAIN_MAX = 16'h4000;

   localparam logic [2:0] ADDR_ATTACK  = 3'd0;
   localparam logic [2:0] ADDR_DECAY   = 3'd1;
   localparam logic [2:0] ADDR_SUSTAIN = 3'd2;
   localparam logic [2:0] ADDR_RELEASE = 3'd3;
   localparam logic [2:0] ADDR_CMD     = 3'd4;
   localparam logic [2:0] ADDR_DIV     = 3'd5;

endpackage

// File: rtl/adsr_tick_gen.sv
// rtl/adsr_tick_gen.sv - free-running prescaler producing a one-cycle tick every div+1 clocks
module adsr_tick_gen
   import adsr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] div,
   output logic        tick
);

   logic [15:0] cnt;

   // >= rather than == so a div lowered below the running count recovers at once
   assign tick = (cnt >= div);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

endmodule

// File: rtl/adsr_env_gen.sv
// rtl/adsr_env_gen.sv - register-programmed ADSR envelope generator driving the DDFS env_ext input
module adsr_env_gen
   import adsr_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs,
   input  logic          read,
   input  logic          write,
   input  logic [4:0]    addr,
   input  logic [31:0]   wr_data,
   output logic [31:0]   rd_data,
   output logic [DW-1:0] env_out,
   output logic          idle,
   output logic          done
);

   adsr_state_t state, state_n;
   logic [31:0] amp, amp_n;
   logic        done_n;

   logic [31:0] attack_step, decay_step, release_step;
   logic [15:0] sustain, div;
   logic        tick;

   logic        wr_en, cmd_wr, cmd_start, cmd_release;
   logic [31:0] sus32;
   logic [32:0] attack_sum, decay_floor;
   logic        unused_bits;

   assign unused_bits = ^{read, addr[4:3]};

   adsr_tick_gen u_tick (
      .clk   (clk),
      .reset (reset),
      .div   (div),
      .tick  (tick)
   );

   assign wr_en  = cs & write;
   assign cmd_wr = wr_en && (addr[2:0] == ADDR_CMD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         attack_step  <= '0;
         decay_step   <= '0;
         release_step <= '0;
         sustain      <= SUSTAIN_MAX;
         div          <= '0;
      end else if (wr_en) begin
         case (addr[2:0])
            ADDR_ATTACK:  attack_step  <= wr_data;
            ADDR_DECAY:   decay_step   <= wr_data;
            ADDR_SUSTAIN: sustain      <= (wr_data[15:0] > SUSTAIN_MAX) ? SUSTAIN_MAX : wr_data[15:0];
            ADDR_RELEASE: release_step <= wr_data;
            ADDR_DIV:     div          <= wr_data[15:0];
            default:      ;
         endcase
      end
   end

   // Start wins over release; release only applies to an envelope that is sounding
   assign cmd_start   = cmd_wr & wr_data[0];
   assign cmd_release = cmd_wr & wr_data[1] &
                        ((state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN));

   // 33-bit sums so neither comparison can be fooled by a 32-bit wrap
   assign sus32       = {sustain, 16'h0000};
   assign attack_sum  = {1'b0, amp} + {1'b0, attack_step};
   assign decay_floor = {1'b0, sus32} + {1'b0, decay_step};

   always_comb begin
      state_n = state;
      amp_n   = amp;
      done_n  = 1'b0;
      if (cmd_start) begin
         state_n = ST_ATTACK;
      end else if (cmd_release) begin
         state_n = ST_RELEASE;
      end else if (tick) begin
         case (state)
            ST_ATTACK: begin
               if (attack_step != '0) begin
                  if (attack_sum >= {1'b0, AMP_MAX}) begin
                     amp_n   = AMP_MAX;
                     state_n = ST_DECAY;
                  end else begin
                     amp_n = attack_sum[31:0];
                  end
               end
            end
            ST_DECAY: begin
               if (decay_step != '0) begin
                  if ({1'b0, amp} <= decay_floor) begin
                     amp_n   = sus32;
                     state_n = ST_SUSTAIN;
                  end else begin
                     amp_n = amp - decay_step;
                  end
               end
            end
            ST_RELEASE: begin
               if (release_step != '0) begin
                  if (amp <= release_step) begin
                     amp_n   = '0;
                     state_n = ST_IDLE;
                     done_n  = 1'b1;
                  end else begin
                     amp_n = amp - release_step;
                  end
               end
            end
            ST_IDLE, ST_SUSTAIN: begin
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         amp   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         amp   <= amp_n;
         done  <= done_n;
      end
   end

   assign env_out = amp[31 -: DW];
   assign idle    = (state == ST_IDLE);
   assign rd_data = {13'b0, state, amp[31:16]};

endmodule

// File: tb/tb_adsr_env_gen.sv
// tb/tb_adsr_env_gen.sv - vector-table and scoreboard bench for adsr_env_gen
module tb_adsr_env_gen;
   import adsr_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cs = 1'b0;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [4:0]  addr = '0;
   logic [31:0] wr_data = '0;
   logic [31:0] rd_data;
   logic [15:0] env_out;
   logic        idle;
   logic        done;

   adsr_env_gen #(.DW(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .cs      (cs),
      .read    (read),
      .write   (write),
      .addr    (addr),
      .wr_data (wr_data),
      .rd_data (rd_data),
      .env_out (env_out),
      .idle    (idle),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [2:0]  a;
      logic [31:0] d;
      logic [15:0] env;
      logic [2:0]  st;
      logic        dn;
   } vec_t;

   typedef struct {
      int          tag;
      logic [31:0] rd;
      logic [15:0] env;
      logic        idl;
      logic        dn;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic void add(logic wr, logic [2:0] a, logic [31:0] d,
                               logic [15:0] env, logic [2:0] st, logic dn);
      vec_t v;
      v.wr = wr; v.a = a; v.d = d; v.env = env; v.st = st; v.dn = dn;
      vecs.push_back(v);
   endfunction

   function automatic exp_t mk_exp(int tag, logic [15:0] env, logic [2:0] st, logic dn);
      exp_t e;
      e.tag = tag;
      e.rd  = {13'b0, st, env};
      e.env = env;
      e.idl = (st == 3'd0);
      e.dn  = dn;
      return e;
   endfunction

   task automatic check_head();
      exp_t        e;
      logic [49:0] act;
      logic [49:0] req;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: no expectation queued");
         return;
      end
      e   = sb.pop_front();
      act = {rd_data, env_out, idle, done};
      req = {e.rd, e.env, e.idl, e.dn};
      if (act !== req) begin
         n_bad++;
         $display("FAIL vec%0d: got rd_data=%h env_out=%h idle=%b done=%b, want rd_data=%h env_out=%h idle=%b done=%b",
                  e.tag, rd_data, env_out, idle, done, e.rd, e.env, e.idl, e.dn);
      end
   endtask

   // Called just after a falling edge: drive one clock of stimulus, check after the next falling edge
   task automatic step(logic wr, logic [2:0] a, logic [31:0] d, int tag,
                       logic [15:0] env, logic [2:0] st, logic dn);
      cs      = wr;
      write   = wr;
      addr    = {2'($urandom_range(0, 3)), a};
      wr_data = d;
      sb.push_back(mk_exp(tag, env, st, dn));
      @(posedge clk);
      @(negedge clk);
      cs    = 1'b0;
      write = 1'b0;
      check_head();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // wr addr          data           env      st   done
      add(1, ADDR_ATTACK,  32'h1000_0000, 16'h0000, 3'd0, 0);
      add(1, ADDR_DECAY,   32'h0800_0000, 16'h0000, 3'd0, 0);
      add(1, ADDR_SUSTAIN, 32'h0000_2000, 16'h0000, 3'd0, 0);
      add(1, ADDR_RELEASE, 32'h1000_0000, 16'h0000, 3'd0, 0);
      add(1, ADDR_CMD,     32'h1,         16'h0000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h1000, 3'd1, 0);
      add(1, ADDR_CMD,     32'h1,         16'h1000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h3000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h3800, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h3000, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h2800, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd3, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd3, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd3, 0);
      add(1, ADDR_CMD,     32'h2,         16'h2000, 3'd4, 0);
      add(0, 3'd0,         32'h0,         16'h1000, 3'd4, 0);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd0, 1);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd0, 0);
      add(1, ADDR_CMD,     32'h2,         16'h0000, 3'd0, 0);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd0, 0);
      add(1, ADDR_ATTACK,  32'h0,         16'h0000, 3'd0, 0);
      add(1, ADDR_CMD,     32'h1,         16'h0000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd1, 0);
      add(1, ADDR_CMD,     32'h2,         16'h0000, 3'd4, 0);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd0, 1);
      add(0, 3'd0,         32'h0,         16'h0000, 3'd0, 0);
      add(1, ADDR_ATTACK,  32'h2000_0000, 16'h0000, 3'd0, 0);
      add(1, ADDR_SUSTAIN, 32'h0000_5000, 16'h0000, 3'd0, 0);
      add(1, ADDR_CMD,     32'h1,         16'h0000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd3, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd3, 0);
      add(1, ADDR_SUSTAIN, 32'h0000_2000, 16'h4000, 3'd3, 0);
      add(1, ADDR_CMD,     32'h1,         16'h4000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h3800, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h3000, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h2800, 3'd2, 0);
      add(0, 3'd0,         32'h0,         16'h2000, 3'd3, 0);
      add(1, ADDR_CMD,     32'h3,         16'h2000, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h4000, 3'd2, 0);
      add(1, ADDR_ATTACK,  32'h0100_0000, 16'h3800, 3'd2, 0);
      add(1, ADDR_CMD,     32'h1,         16'h3800, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h3900, 3'd1, 0);
      add(0, 3'd0,         32'h0,         16'h3A00, 3'd1, 0);

      reset = 1'b1;
      repeat (3) @(negedge clk);
      sb.push_back(mk_exp(1000, 16'h0000, 3'd0, 1'b0));
      check_head();
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].wr, vecs[i].a, vecs[i].d, i, vecs[i].env, vecs[i].st, vecs[i].dn);
      end

      // Asynchronous reset in the middle of ATTACK, observed before the next rising edge
      #2 reset = 1'b1;
      #1;
      sb.push_back(mk_exp(2000, 16'h0000, 3'd0, 1'b0));
      check_head();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         sb.push_back(mk_exp(2001 + k, 16'h0000, 3'd0, 1'b0));
         check_head();
      end
      reset = 1'b0;

      // div=3: the first tick after start lands on the second clock, then every fourth
      step(1, ADDR_DIV,    32'd3,         3000, 16'h0000, 3'd0, 0);
      step(1, ADDR_ATTACK, 32'h1000_0000, 3001, 16'h0000, 3'd0, 0);
      step(1, ADDR_CMD,    32'h1,         3002, 16'h0000, 3'd1, 0);
      for (int k = 0; k < 12; k++) begin
         step(0, 3'd0, 32'h0, 3003 + k, 16'((k + 3) / 4 * 16'h1000), 3'd1, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adsr_env_gen.md
ADSR_ENV_GEN -- requirements
Module: adsr_env_gen

Interface
REQ-001 SHALL have parameter DW, default 16, meaning envelope output width (Q2.14, 0x4000 = 1.0).
REQ-002 SHALL have clock clk; reset reset, asynchronous, active-high.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port cs  input  1  slot select.
REQ-006 SHALL have port read  input  1  slot read strobe (no side effects).
REQ-007 SHALL have port write  input  1  slot write strobe.
REQ-008 SHALL have port addr  input  5  register address, addr[2:0] decoded.
REQ-009 SHALL have port wr_data  input  32  write data.
REQ-010 SHALL have port rd_data  output  32  status {13'b0, state[2:0], env_out}.
REQ-011 SHALL have port env_out  output  DW  envelope to the DDFS env_ext input.
REQ-012 SHALL have port idle  output  1  high when state is IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on RELEASE->IDLE.

Function
REQ-014 SHALL decode writes (cs & write): 0 attack_step[31:0], 1 decay_step[31:0], 2 sustain[15:0], 3 release_step[31:0], 4 command (bit0 start, bit1 release; not stored), 5 div[15:0].
REQ-015 SHALL clamp a sustain write above 0x4000 to 0x4000.
REQ-016 SHALL hold a 32-bit unsigned amplitude amp, MAX = 0x4000_0000; env_out = amp[31:16], driven from the register.
REQ-017 SHALL generate tick, a one-cycle pulse every div+1 clocks from a free-running counter (div=0: every cycle).
REQ-018 SHALL implement states IDLE(0), ATTACK(1), DECAY(2), SUSTAIN(3), RELEASE(4), encoded as shown in rd_data.
REQ-019 SHALL enter ATTACK the cycle after a start command from any state, keeping the current amp (retrigger, no reset to 0).
REQ-020 SHALL enter RELEASE the cycle after a release command from ATTACK, DECAY or SUSTAIN; ignored in IDLE and RELEASE.
REQ-021 SHALL give start priority when start and release are set in the same write.
REQ-022 SHALL update amp only on tick and only from the following cycle onwards after a state change; a command cycle performs no step.
REQ-023 ATTACK on tick: if amp + attack_step >= MAX (33-bit compare), amp = MAX and go DECAY; else amp += attack_step.
REQ-024 DECAY on tick: if amp <= sus32 + decay_step, amp = sus32 and go SUSTAIN; else amp -= decay_step; sus32 = {sustain,16'h0}.
REQ-025 SUSTAIN SHALL hold amp unchanged indefinitely.
REQ-026 RELEASE on tick: if amp <= release_step, amp = 0, go IDLE and pulse done; else amp -= release_step.
REQ-027 A step value of 0 SHALL hold amp and state (no progress) in that phase.
REQ-028 Step/sustain writes mid-phase SHALL take effect at the next tick.
REQ-029 amp SHALL never exceed MAX nor wrap below 0.

Reset
REQ-030 On reset: state IDLE, amp 0, env_out 0, idle 1, done 0, all steps 0, sustain 0x4000, div 0, tick counter 0.
REQ-031 Reset mid-envelope SHALL abort immediately without a done pulse.

Structure
REQ-032 Package adsr_pkg SHALL hold the state enum, MAX constant and register address constants.
REQ-033 Sub-module adsr_tick_gen SHALL implement the div prescaler.

Verification
REQ-034 div=0, attack_step=0x1000_0000, start -> env_out 0x1000,0x2000,0x3000,0x4000 on successive cycles, then state DECAY.
REQ-035 then decay_step=0x0800_0000, sustain=0x2000 -> env 0x3800,0x3000,0x2800,0x2000, state SUSTAIN, holds.
REQ-036 release with release_step=0x1000_0000 -> env 0x1000, then 0x0000, idle=1, done high exactly one cycle.
REQ-037 div=3 -> amp changes only every 4th clock; release written during IDLE -> no state change.
REQ-038 start+release in one write during SUSTAIN at 0x2000 -> ATTACK from 0x2000; reset asserted mid-ATTACK -> env 0, idle 1, done 0.
